// File: rtl/cmpx_node.sv
// cmpx_node: compare-exchange node for a sorting mesh.
// Accepts one key/tag operand pair per transaction. Keys are compared
// unsigned, and each tag travels with its key. The result is registered
// behind a one-deep valid/ready output stage.
// The optional saturating exchange counter is enabled by the macro
// CMPX_NODE_SWAP_CNT_EN. Without the macro, swap_cnt reads 0 and
// swap_cnt_clr is ignored.
module cmpx_node #(
  parameter int WIDTH   = 8,
  parameter int TAG_W   = 4,
  parameter int ROW_IDX = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_key,
  input  logic [TAG_W-1:0] a_tag,
  input  logic [WIDTH-1:0] b_key,
  input  logic [TAG_W-1:0] b_tag,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] lo_key,
  output logic [TAG_W-1:0] lo_tag,
  output logic [WIDTH-1:0] hi_key,
  output logic [TAG_W-1:0] hi_tag,
  output logic             swapped,
  input  logic             swap_cnt_clr,
  output logic [15:0]      swap_cnt
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  // In snake mode, odd rows sort descending.
  localparam logic ROW_ODD = (ROW_IDX % 2) != 0;

  logic [0:0]       state_q, state_d;
  logic             accept;
  logic             drain;
  logic             desc;
  logic             exch;
  logic [WIDTH-1:0] lo_key_q, lo_key_d;
  logic [TAG_W-1:0] lo_tag_q, lo_tag_d;
  logic [WIDTH-1:0] hi_key_q, hi_key_d;
  logic [TAG_W-1:0] hi_tag_q, hi_tag_d;
  logic             swapped_q;

  assign in_ready  = (state_q == EMPTY) | out_ready;
  assign out_valid = (state_q == FULL);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  assign lo_key  = lo_key_q;
  assign lo_tag  = lo_tag_q;
  assign hi_key  = hi_key_q;
  assign hi_tag  = hi_tag_q;
  assign swapped = swapped_q;

  // Compare-exchange datapath; equal keys never exchange.
  always_comb begin
    desc = 1'b0;
    case (mode)
      2'b01:   desc = 1'b1;
      2'b10:   desc = ROW_ODD;
      default: desc = 1'b0;
    endcase
    exch = (mode != 2'b11) && (desc ? (a_key < b_key) : (a_key > b_key));
    lo_key_d = exch ? b_key : a_key;
    lo_tag_d = exch ? b_tag : a_tag;
    hi_key_d = exch ? a_key : b_key;
    hi_tag_d = exch ? a_tag : b_tag;
  end

  // Next-state logic: accept wins over drain, so back-to-back traffic stays FULL.
  always_comb begin
    state_d = state_q;
    if (accept)     state_d = FULL;
    else if (drain) state_d = EMPTY;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Result register: loads only on accept, so the result holds through stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_key_q  <= '0;
      lo_tag_q  <= '0;
      hi_key_q  <= '0;
      hi_tag_q  <= '0;
      swapped_q <= 1'b0;
    end else if (accept) begin
      lo_key_q  <= lo_key_d;
      lo_tag_q  <= lo_tag_d;
      hi_key_q  <= hi_key_d;
      hi_tag_q  <= hi_tag_d;
      swapped_q <= exch;
    end
  end

`ifdef CMPX_NODE_SWAP_CNT_EN
  logic [15:0] swap_cnt_q;

  // Saturating exchange counter; the clear takes priority over a same-cycle swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   swap_cnt_q <= '0;
    else if (swap_cnt_clr)                       swap_cnt_q <= '0;
    else if (accept && exch && swap_cnt_q != '1) swap_cnt_q <= swap_cnt_q + 16'd1;
  end

  assign swap_cnt = swap_cnt_q;
`else
  logic unused_swap_cnt_clr;
  assign unused_swap_cnt_clr = swap_cnt_clr;
  assign swap_cnt            = '0;
`endif

endmodule
